// File: rtl/uart_num_parser.sv
// Parses ASCII signed decimal integers from a UART byte stream into a FWFT FIFO
// of values and end-of-row markers, popped downstream through valid/ready.
module uart_num_parser #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    output logic [DATA_WIDTH-1:0]         num_data,
    output logic                          num_eol,
    output logic                          num_valid,
    input  logic                          num_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          parse_err,
    output logic                          sat,
    output logic                          overflow
);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int ACC_W = DATA_WIDTH + 1;
    localparam int MUL_W = ACC_W + 4;
    localparam logic [ACC_W-1:0] ACC_LIM = ACC_W'(1) << (DATA_WIDTH - 1);
    localparam logic [ACC_W-1:0] POS_MAX = ACC_LIM - ACC_W'(1);

    // Downstream handshake: an entry transfers on any cycle where num_valid && num_ready.
    typedef enum logic [2:0] {S_IDLE, S_SIGN, S_DIGIT, S_EOL, S_ERROR} state_t;
    state_t state, state_d;

    logic [ACC_W-1:0] acc, acc_d;
    logic             neg, neg_d, clamped, clamped_d, line_has_data, lhd_d;
    logic             push_req, push_eol, push_sat, perr;
    logic [DATA_WIDTH-1:0] push_data;

    logic       is_digit, is_minus, is_sep, is_lend;
    logic [3:0] dval;
    logic [MUL_W-1:0] acc_mul;
    logic [ACC_W-1:0] neg_mag;

    assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_minus = (rx_data == 8'h2D);
    assign is_sep   = (rx_data == 8'h20) || (rx_data == 8'h2C) || (rx_data == 8'h09);
    assign is_lend  = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    assign dval     = rx_data[3:0];
    assign acc_mul  = MUL_W'(acc) * MUL_W'(10) + MUL_W'(dval);
    assign neg_mag  = ACC_W'(0) - acc;

    // clamped remembers that the digit string ever exceeded the magnitude limit,
    // which distinguishes "-32768" (exact) from "-40000" (clamped).
    always_comb begin
        push_data = '0;
        push_sat  = 1'b0;
        if (neg) begin
            push_data = neg_mag[DATA_WIDTH-1:0];
            push_sat  = clamped;
        end else if (acc > POS_MAX) begin
            push_data = POS_MAX[DATA_WIDTH-1:0];
            push_sat  = 1'b1;
        end else begin
            push_data = acc[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        state_d   = state;
        acc_d     = acc;
        neg_d     = neg;
        clamped_d = clamped;
        lhd_d     = line_has_data;
        push_req  = 1'b0;
        push_eol  = 1'b0;
        perr      = 1'b0;
        case (state)
            S_IDLE: if (rx_valid) begin
                if (is_digit) begin
                    acc_d = ACC_W'(dval); neg_d = 1'b0; clamped_d = 1'b0; state_d = S_DIGIT;
                end else if (is_minus) begin
                    neg_d = 1'b1; state_d = S_SIGN;
                end else if (is_lend) begin
                    state_d = line_has_data ? S_EOL : S_IDLE;
                end else if (!is_sep) begin
                    perr = 1'b1; state_d = S_ERROR;
                end
            end
            S_SIGN: if (rx_valid) begin
                if (is_digit) begin
                    acc_d = ACC_W'(dval); clamped_d = 1'b0; state_d = S_DIGIT;
                end else if (is_sep) begin
                    perr = 1'b1; state_d = S_IDLE;
                end else if (is_lend) begin
                    perr = 1'b1; state_d = line_has_data ? S_EOL : S_IDLE;
                end else begin
                    perr = 1'b1; state_d = S_ERROR;
                end
            end
            S_DIGIT: if (rx_valid) begin
                if (is_digit) begin
                    if (acc_mul > MUL_W'(ACC_LIM)) begin
                        acc_d = ACC_LIM; clamped_d = 1'b1;
                    end else begin
                        acc_d = acc_mul[ACC_W-1:0];
                    end
                end else if (is_sep || is_lend) begin
                    push_req = 1'b1; lhd_d = 1'b1;
                    state_d  = is_lend ? S_EOL : S_IDLE;
                end else begin
                    perr = 1'b1; state_d = S_ERROR;
                end
            end
            S_EOL: begin
                push_req = 1'b1; push_eol = 1'b1; lhd_d = 1'b0; state_d = S_IDLE;
            end
            S_ERROR: if (rx_valid) begin
                if (is_sep) state_d = S_IDLE;
                else if (is_lend) state_d = line_has_data ? S_EOL : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic            full, do_pop, do_push;
    logic [DATA_WIDTH:0] mem [FIFO_DEPTH];

    assign full      = (fifo_count == (PW+1)'(FIFO_DEPTH));
    assign num_valid = (fifo_count != '0);
    assign do_pop    = num_valid && num_ready;
    assign do_push   = push_req && (!full || do_pop);
    assign num_data  = num_valid ? mem[rd_ptr][DATA_WIDTH-1:0] : '0;
    assign num_eol   = num_valid && mem[rd_ptr][DATA_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            acc           <= '0;
            neg           <= 1'b0;
            clamped       <= 1'b0;
            line_has_data <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            parse_err     <= 1'b0;
            sat           <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            state         <= state_d;
            acc           <= acc_d;
            neg           <= neg_d;
            clamped       <= clamped_d;
            line_has_data <= lhd_d;
            parse_err     <= perr;
            sat           <= push_req && !push_eol && push_sat;
            overflow      <= push_req && !do_push;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Marker entries carry data 0 so the head value reads 0 for them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {push_eol, (push_eol ? {DATA_WIDTH{1'b0}} : push_data)};
    end
endmodule

// File: tb/tb_uart_num_parser.sv
// Bench for uart_num_parser: directed strings plus random byte streams, checked
// against a token-level reference model feeding an expected-entry queue.
module tb_uart_num_parser;
    localparam int W = 16;
    localparam int D = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic [7:0] rx_data;
    logic rx_valid;
    logic [W-1:0] num_data;
    logic num_eol, num_valid, num_ready;
    logic [$clog2(D):0] fifo_count;
    logic parse_err, sat, overflow;

    uart_num_parser #(.DATA_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .num_data(num_data), .num_eol(num_eol), .num_valid(num_valid),
        .num_ready(num_ready), .fifo_count(fifo_count), .parse_err(parse_err),
        .sat(sat), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: whole tokens between separators / line ends.
    logic [W:0] exp_q[$];
    logic [7:0] tok[$];
    bit   line_has = 0;
    bit   hold_mode = 0;
    int   hold_pending = 0;
    int   exp_pushes = 0, exp_perr = 0, exp_sat = 0, exp_ovf = 0;

    task automatic model_push(input logic [W:0] e);
        if (hold_mode && hold_pending >= D) begin
            exp_ovf++;
        end else begin
            exp_q.push_back(e);
            exp_pushes++;
            if (hold_mode) hold_pending++;
        end
    endtask

    task automatic model_token();
        bit ok = 1;
        bit ng = 0;
        int start = 0;
        longint mag = 0;
        int v;
        logic [W-1:0] vv;
        if (tok.size() == 0) return;
        if (tok[0] == "-") begin ng = 1; start = 1; end
        if (tok.size() == start) ok = 0;
        for (int i = start; i < tok.size(); i++) begin
            if (tok[i] < "0" || tok[i] > "9") ok = 0;
            else begin
                mag = mag * 10 + (tok[i] - "0");
                if (mag > 1000000) mag = 1000000;
            end
        end
        if (!ok) exp_perr++;
        else begin
            if (ng) begin
                if (mag > 32768) begin v = -32768; exp_sat++; end
                else v = -int'(mag);
            end else begin
                if (mag > 32767) begin v = 32767; exp_sat++; end
                else v = int'(mag);
            end
            vv = v[W-1:0];
            model_push({1'b0, vv});
            line_has = 1;
        end
        tok.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'h20 || b == 8'h2C || b == 8'h09) model_token();
        else if (b == 8'h0D || b == 8'h0A) begin
            model_token();
            if (line_has) begin model_push({1'b1, {W{1'b0}}}); line_has = 0; end
        end else tok.push_back(b);
    endtask

    // Driver tasks
    bit ready_hold = 1;
    bit rand_ready = 0;
    always @(posedge clk) begin
        #1;
        num_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_hold;
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b; rx_valid = 1'b1;
        model_byte(b);
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    // Scoreboard: pops compared against the expected queue, pulses counted.
    int pops = 0, seen_perr = 0, seen_sat = 0, seen_ovf = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (parse_err) seen_perr++;
            if (sat) seen_sat++;
            if (overflow) seen_ovf++;
            if (num_valid && num_ready) begin
                pops++;
                if (exp_q.size() > 0) check("pop_entry", {num_eol, num_data}, exp_q.pop_front());
            end
        end
    end

    task automatic drain(input string tag);
        int n = 0;
        while (pops != exp_pushes && n < 600) begin @(posedge clk); n++; end
        repeat (4) @(posedge clk);
        @(negedge clk);
        check({tag, "_pops"}, pops, exp_pushes);
        check({tag, "_empty"}, num_valid, 0);
        check({tag, "_perr"}, seen_perr, exp_perr);
        check({tag, "_sat"}, seen_sat, exp_sat);
        check({tag, "_ovf"}, seen_ovf, exp_ovf);
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check(tag, {num_valid, num_eol, parse_err, sat, overflow, fifo_count, num_data}, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        check_reset_outputs("reset_outputs");
        @(posedge clk); #1 rst_n = 1'b1;

        send_str("123 -45\r\n");             drain("t1_basic");
        send_str("99999 -40000,-32768\n");   drain("t2_sat");
        send_str("1a2 7\n");                 drain("t3_illegal");
        send_str("- 5  ,,6\n\n");            drain("t4_lone_minus");

        ready_hold = 0; hold_mode = 1; hold_pending = 0;
        send_str("1 2 3 4 5 6 7 8 9 ");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("hold_count", fifo_count, D);
        check("hold_head", {num_eol, num_data}, exp_q[0]);
        hold_mode = 0; ready_hold = 1;
        drain("t5_overflow");

        send_str("12");
        @(posedge clk); #1 rst_n = 1'b0;
        tok.delete(); line_has = 0; exp_q.delete();
        repeat (2) @(posedge clk);
        check_reset_outputs("midrun_reset_outputs");
        #1 rst_n = 1'b1;
        send_str("3 ");                      drain("t6_reset");

        rand_ready = 1;
        for (int i = 0; i < 300; i++) begin
            int r = $urandom_range(0, 99);
            if (r < 4) send_str($sformatf("%0d ", $urandom_range(30000, 999999)));
            else if (r < 55) send_byte(8'h30 + 8'($urandom_range(0, 9)));
            else if (r < 63) send_byte(8'h2D);
            else if (r < 75) send_byte(8'h20);
            else if (r < 80) send_byte(8'h2C);
            else if (r < 83) send_byte(8'h09);
            else if (r < 89) send_byte(8'h0A);
            else if (r < 92) send_byte(8'h0D);
            else send_byte(8'h41 + 8'($urandom_range(0, 25)));
        end
        send_byte(8'h0A);
        rand_ready = 0; ready_hold = 1;
        drain("t7_random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
